// File: rtl/instr_fetch_stage_if.sv
// Instruction fetch bus bundle.
// Carries the word-addressed instruction memory port and the registered
// IF/ID output that feeds decode.
//   imem_addr : word address to instruction memory (fetch stage drives)
//   imem_data : instruction word returned combinationally by memory
//   if_instr  : registered instruction handed to decode
//   if_pc     : word address of if_instr
//   if_valid  : if_instr/if_pc hold a live instruction
// There is no backpressure on this bus. Decode must consume if_instr on
// every cycle where if_valid=1. Holding a word in place is the job of the
// fetch stage's stall input.
interface instr_fetch_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_data;
    logic [31:0]           if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  if_valid;

    // The fetch stage is the master side.
    modport master (
        output imem_addr,
        input  imem_data,
        output if_instr,
        output if_pc,
        output if_valid
    );

    // Memory and decode together form the slave side.
    modport slave (
        input  imem_addr,
        output imem_data,
        input  if_instr,
        input  if_pc,
        input  if_valid
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Program counter and fetch stage placed in front of a word-addressed,
// zero-latency instruction memory.
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   stall                : hold PC and the IF/ID register
//   flush                : invalidate IF/ID and skip the word fetched this cycle
//   branch_taken/_target : redirect the PC. An out-of-range target halts with fault.
//   halt_req             : stop fetching until reset
//   bus                  : imem address/data and the IF/ID outputs (master side)
//   halted, fault        : fetch stopped; fault means an illegal branch target caused it
//   fetch_count          : saturating count of words accepted into IF/ID
//   state_dbg            : current FSM state (0=BOOT, 1=RUN, 2=HALT)
module instr_fetch_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 128,
    parameter int RESET_PC   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt_req,
    instr_fetch_stage_if.master   bus,
    output logic                  halted,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  fetch_count,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t                r_state,  w_state_nx;
    logic [ADDR_WIDTH-1:0] r_pc,     w_pc_nx;
    logic [31:0]           r_instr,  w_instr_nx;
    logic [ADDR_WIDTH-1:0] r_if_pc,  w_if_pc_nx;
    logic                  r_valid,  w_valid_nx;
    logic                  r_halted, w_halted_nx;
    logic                  r_fault,  w_fault_nx;
    logic [CNT_WIDTH-1:0]  r_cnt,    w_cnt_nx;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_tgt_bad;

    // Sequential PC. It wraps at the top of memory, so the PC never leaves
    // the legal range.
    assign w_next_pc = (r_pc == ADDR_WIDTH'(MEM_WORDS - 1)) ? '0 : r_pc + 1'b1;
    assign w_tgt_bad = (branch_target >= ADDR_WIDTH'(MEM_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BOOT;
            r_pc     <= ADDR_WIDTH'(RESET_PC);
            r_instr  <= '0;
            r_if_pc  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_instr  <= w_instr_nx;
            r_if_pc  <= w_if_pc_nx;
            r_valid  <= w_valid_nx;
            r_halted <= w_halted_nx;
            r_fault  <= w_fault_nx;
            r_cnt    <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_instr_nx  = r_instr;
        w_if_pc_nx  = r_if_pc;
        w_valid_nx  = r_valid;
        w_halted_nx = r_halted;
        w_fault_nx  = r_fault;
        w_cnt_nx    = r_cnt;
        case (r_state)
            BOOT: begin
                // One bubble cycle. Nothing is fetched and the PC stays put.
                if (halt_req) begin
                    w_state_nx  = HALT;
                    w_halted_nx = 1'b1;
                end else begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                // Priority order: halt, bad branch, branch, flush, stall, fetch.
                if (halt_req) begin
                    w_state_nx  = HALT;
                    w_halted_nx = 1'b1;
                    w_valid_nx  = 1'b0;
                end else if (branch_taken && w_tgt_bad) begin
                    w_state_nx  = HALT;
                    w_halted_nx = 1'b1;
                    w_fault_nx  = 1'b1;
                    w_valid_nx  = 1'b0;
                end else if (branch_taken) begin
                    // The word on imem_data is wrong-path, so it is dropped.
                    w_pc_nx    = branch_target;
                    w_valid_nx = 1'b0;
                end else if (flush) begin
                    w_pc_nx    = w_next_pc;
                    w_valid_nx = 1'b0;
                end else if (stall) begin
                    w_pc_nx = r_pc;
                end else begin
                    w_instr_nx = bus.imem_data;
                    w_if_pc_nx = r_pc;
                    w_valid_nx = 1'b1;
                    w_pc_nx    = w_next_pc;
                    if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            HALT: begin
                w_valid_nx = 1'b0;
            end
            default: begin
                w_state_nx  = HALT;
                w_halted_nx = 1'b1;
                w_valid_nx  = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr = r_pc;
    assign bus.if_instr  = r_instr;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_valid  = r_valid;
    assign halted        = r_halted;
    assign fault         = r_fault;
    assign fetch_count   = r_cnt;
    assign state_dbg     = r_state;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed and lightly randomised bench for instr_fetch_stage. It uses an
// expected-fetch queue and a second 4-bit-counter instance that exercises
// counter saturation.
module tb_instr_fetch_stage;
    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          rst_s_n;
    logic          stall;
    logic          flush;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          halt_req;
    logic          halted;
    logic          fault;
    logic [15:0]   fetch_count;
    logic [1:0]    state_dbg;
    logic          halted_s;
    logic          fault_s;
    logic [3:0]    fetch_count_s;
    logic [1:0]    state_s;
    logic          zero_b;
    logic [AW-1:0] zero_w;

    logic [31:0] mem [0:127];
    logic [63:0] exp_q [$];
    int          checks;
    int          failures;
    int          exp_cnt;
    int          mpc;
    logic        do_stall;

    instr_fetch_stage_if #(.ADDR_WIDTH(AW)) ifc ();
    instr_fetch_stage_if #(.ADDR_WIDTH(AW)) ifs ();

    assign ifc.imem_data = mem[ifc.imem_addr[6:0]];
    assign ifs.imem_data = mem[ifs.imem_addr[6:0]];
    assign zero_b = 1'b0;
    assign zero_w = '0;

    instr_fetch_stage #(.ADDR_WIDTH(AW), .MEM_WORDS(128), .RESET_PC(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
        .bus(ifc.master), .halted(halted), .fault(fault),
        .fetch_count(fetch_count), .state_dbg(state_dbg)
    );

    instr_fetch_stage #(.ADDR_WIDTH(AW), .MEM_WORDS(128), .RESET_PC(0), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_s_n), .stall(zero_b), .flush(zero_b),
        .branch_taken(zero_b), .branch_target(zero_w), .halt_req(zero_b),
        .bus(ifs.master), .halted(halted_s), .fault(fault_s),
        .fetch_count(fetch_count_s), .state_dbg(state_s)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // Driver and check tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input int a);
        exp_q.push_back({32'(a), mem[a[6:0]]});
        exp_cnt++;
    endtask

    task automatic pop_chk(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc_instr"}, {ifc.if_pc, ifc.if_instr}, e);
            chk({tag, "_valid"}, 64'(ifc.if_valid), 64'd1);
            chk({tag, "_count"}, 64'(fetch_count), 64'(exp_cnt));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(ifc.if_valid), 64'd0);
        chk({tag, "_instr"}, 64'(ifc.if_instr), 64'd0);
        chk({tag, "_ifpc"}, 64'(ifc.if_pc), 64'd0);
        chk({tag, "_addr"}, 64'(ifc.imem_addr), 64'd0);
        chk({tag, "_halted"}, 64'(halted), 64'd0);
        chk({tag, "_fault"}, 64'(fault), 64'd0);
        chk({tag, "_count"}, 64'(fetch_count), 64'd0);
        chk({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // Directed sequence
    initial begin
        checks = 0; failures = 0; exp_cnt = 0;
        rst_n = 1'b0; rst_s_n = 1'b0;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'hA00000AA;
        mem[1] = 32'h10000011;
        mem[2] = 32'h20000022;
        mem[9] = 32'h90000099;
        #2;
        chk_reset("reset");

        @(negedge clk);
        rst_n = 1'b1; rst_s_n = 1'b1;
        cyc();
        chk("boot_valid", 64'(ifc.if_valid), 64'd0);
        chk("boot_addr", 64'(ifc.imem_addr), 64'd0);
        chk("boot_state", 64'(state_dbg), 64'd1);

        push_fetch(0); cyc(); pop_chk("fetch0");
        chk("fetch0_addr", 64'(ifc.imem_addr), 64'd1);
        push_fetch(1); cyc(); pop_chk("fetch1");
        chk("small_count2", 64'(fetch_count_s), 64'd2);

        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_instr", 64'(ifc.if_instr), 64'h10000011);
            chk("stall_ifpc", 64'(ifc.if_pc), 64'd1);
            chk("stall_addr", 64'(ifc.imem_addr), 64'd2);
            chk("stall_count", 64'(fetch_count), 64'(exp_cnt));
        end
        stall = 1'b0;
        push_fetch(2); cyc(); pop_chk("fetch2");
        chk("count3", 64'(fetch_count), 64'd3);

        // Branch wins over stall
        branch_taken = 1'b1; branch_target = 32'd9; stall = 1'b1;
        cyc();
        chk("br_valid", 64'(ifc.if_valid), 64'd0);
        chk("br_addr", 64'(ifc.imem_addr), 64'd9);
        chk("br_count", 64'(fetch_count), 64'(exp_cnt));
        branch_taken = 1'b0; stall = 1'b0;
        push_fetch(9); cyc(); pop_chk("fetch9");

        // Flush wins over stall and skips the word at 10
        flush = 1'b1; stall = 1'b1;
        cyc();
        chk("flush_valid", 64'(ifc.if_valid), 64'd0);
        chk("flush_addr", 64'(ifc.imem_addr), 64'd11);
        flush = 1'b0; stall = 1'b0;
        push_fetch(11); cyc(); pop_chk("fetch11");

        // PC wraps from the last word to 0
        branch_taken = 1'b1; branch_target = 32'd127;
        cyc();
        branch_taken = 1'b0;
        push_fetch(127); cyc(); pop_chk("fetch127");
        chk("wrap_addr", 64'(ifc.imem_addr), 64'd0);
        push_fetch(0); cyc(); pop_chk("fetch_wrap0");

        // Illegal target halts with fault, then everything stays frozen
        branch_taken = 1'b1; branch_target = 32'd128;
        cyc();
        chk("fault_halted", 64'(halted), 64'd1);
        chk("fault_fault", 64'(fault), 64'd1);
        chk("fault_valid", 64'(ifc.if_valid), 64'd0);
        chk("fault_state", 64'(state_dbg), 64'd2);
        repeat (10) begin
            stall = 1'($urandom_range(0, 1));
            flush = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            branch_target = 32'($urandom_range(0, 200));
            cyc();
            chk("frz_halted", 64'(halted), 64'd1);
            chk("frz_fault", 64'(fault), 64'd1);
            chk("frz_valid", 64'(ifc.if_valid), 64'd0);
            chk("frz_addr", 64'(ifc.imem_addr), 64'd1);
            chk("frz_ifpc", 64'(ifc.if_pc), 64'd0);
            chk("frz_count", 64'(fetch_count), 64'(exp_cnt));
        end
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // Asynchronous reset in the middle of a cycle
        #3 rst_n = 1'b0;
        #1 chk_reset("areset");
        exp_cnt = 0;
        #2 rst_n = 1'b1;
        cyc();
        chk("boot2_valid", 64'(ifc.if_valid), 64'd0);

        // Random stalls with a scoreboarded fetch stream
        mpc = 0;
        repeat (16) begin
            do_stall = 1'($urandom_range(0, 1));
            stall = do_stall;
            if (!do_stall) push_fetch(mpc);
            cyc();
            if (!do_stall) begin
                pop_chk("rnd_fetch");
                mpc++;
            end else begin
                chk("rnd_stall_addr", 64'(ifc.imem_addr), 64'(mpc));
            end
        end
        stall = 1'b0;

        // A halt request stops fetch without setting fault
        halt_req = 1'b1;
        cyc();
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_fault", 64'(fault), 64'd0);
        chk("halt_valid", 64'(ifc.if_valid), 64'd0);
        chk("halt_addr", 64'(ifc.imem_addr), 64'(mpc));
        halt_req = 1'b0;
        cyc();
        chk("halt_hold_addr", 64'(ifc.imem_addr), 64'(mpc));
        chk("halt_hold_state", 64'(state_dbg), 64'd2);

        // Reset during a stalled branch drops the pending redirect
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_reset("areset2");
        #2 rst_n = 1'b1;
        cyc();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd5;
        #3 rst_n = 1'b0;
        #1 chk_reset("areset_mid_branch");
        stall = 1'b0; branch_taken = 1'b0;
        #2 rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_reset_addr", 64'(ifc.imem_addr), 64'd1);

        // The 4-bit counter has seen far more than 15 fetches
        chk("small_sat", 64'(fetch_count_s), 64'd15);
        cyc();
        chk("small_sat_hold", 64'(fetch_count_s), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Program-counter and fetch stage placed directly upstream of the word-addressed instruction memory.
- Drives the memory's word address and latches the returned 32-bit word into a registered IF/ID output with its PC and a valid flag.
- Handles stall, flush, branch redirect and halt.
- Feeds the decode stage.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address bus
MEM_WORDS, 128, number of instruction words; legal PC range is 0..MEM_WORDS-1
RESET_PC, 0, PC loaded on reset (word index)
CNT_WIDTH, 16, width of fetched-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC and IF/ID register
flush  input  1  squash IF/ID contents (invalidate only)
branch_taken  input  1  redirect PC to branch_target
branch_target  input  ADDR_WIDTH  redirect word address
halt_req  input  1  stop fetching permanently until reset
imem_addr  output  ADDR_WIDTH  word address to instruction memory (combinational from PC)
imem_data  input  32  instruction word from memory (combinational read, same cycle)
if_instr  output  32  registered instruction
if_pc  output  ADDR_WIDTH  registered PC of if_instr
if_valid  output  1  if_instr/if_pc hold a live instruction
halted  output  1  fetch stopped
fault  output  1  halted due to illegal branch target
fetch_count  output  CNT_WIDTH  number of instructions accepted into IF/ID, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate, any state):
  - pc=RESET_PC; state=BOOT.
  - if_instr=0, if_pc=0, if_valid=0, halted=0, fault=0, fetch_count=0.
- imem_addr = pc at all times; no internal memory latency assumed.
- States:
  - BOOT: one bubble cycle after reset release. if_valid stays 0; PC not advanced. Next state is RUN unconditionally, except halt_req=1 goes to HALT.
  - RUN, per rising edge, first matching rule wins:
    1. halt_req=1 -> state=HALT, halted=1, if_valid<=0, pc held.
    2. branch_taken=1 and branch_target>=MEM_WORDS -> state=HALT, halted=1, fault=1, if_valid<=0.
    3. branch_taken=1 (legal target) -> pc<=branch_target, if_valid<=0. The word fetched this cycle is wrong-path and discarded. Overrides stall.
    4. flush=1 -> if_valid<=0, pc<=pc+1 (the current fetch is also discarded). Overrides stall.
    5. stall=1 -> pc, if_instr, if_pc, if_valid all held; fetch_count held.
    6. Otherwise -> if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=next_pc, fetch_count<=fetch_count+1.
  - HALT: all outputs frozen except if_valid=0. Inputs are ignored. The only exit is reset.
- next_pc = pc+1, wrapping to 0 when pc=MEM_WORDS-1. PC never holds a value >= MEM_WORDS.
- fetch_count saturates at all-ones; it does not wrap.
- Fetch latency: an instruction at address A appears on if_instr with if_valid=1 one cycle after imem_addr=A, absent stall/flush/branch.
- Throughput: one instruction per cycle in RUN without stall.
- Simultaneous events:
  - flush and stall together -> flush wins.
  - branch_taken and flush together -> branch rule.
  - halt_req beats everything.
- Reset asserted mid-stall or mid-branch: immediate return to reset values; pending redirect is lost.

Test Plan:
- Memory preloaded word0=0xA00000AA, word1=0x10000011, word2=0x20000022. Release reset, no stall -> cycle 1 BOOT (if_valid=0); then if_instr=0xA00000AA/if_pc=0, 0x10000011/1, 0x20000022/2 on consecutive cycles; fetch_count=3.
- stall=1 for 3 cycles while if_pc=1 -> if_instr holds 0x10000011, imem_addr holds 2, fetch_count unchanged; after release, next if_instr=0x20000022.
- branch_taken=1, target=9 (word9=0x90000099) with stall=1 simultaneously -> next cycle if_valid=0, imem_addr=9; following cycle if_instr=0x90000099, if_pc=9.
- PC at 127, no stall -> next imem_addr=0 and if_pc=127; branch to target 128 -> halted=1, fault=1, if_valid=0; stays frozen for 10 cycles.
- halt_req=1 in RUN -> halted=1, fault=0. Then rst_n=0 asynchronously mid-cycle -> all outputs reset immediately, imem_addr=RESET_PC.
- Force fetch_count to all-ones (CNT_WIDTH=4 override, run 20 cycles) -> fetch_count=15 and holds.
